// File: rtl/control_ascensor.sv
// Elevator motion/door controller: queries the request memory, moves the cabin one floor at a time, runs the doors.
// All outputs registered; query-to-decision 3 cycles; obtener strobe period >= 4 cycles.
module control_ascensor #(
  parameter int unsigned CICLOS_PISO   = 100,
  parameter int unsigned CICLOS_PUERTA = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] memoria,
  input  logic       abrir,
  output logic       obtener,
  output logic [1:0] piso_m,
  output logic [1:0] accion_m,
  output logic       puertas_m,
  output logic [1:0] destino
);

  typedef enum logic [2:0] {
    REPOSO, SUBIR, BAJAR, LLEGADA, ABRIR, ABIERTA
  } estado_t;

  localparam logic [15:0] PISO_FIN   = 16'(CICLOS_PISO - 1);
  localparam logic [15:0] PUERTA_FIN = 16'(CICLOS_PUERTA - 1);

  estado_t     estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fase_q, fase_d;
  logic        obtener_q, obtener_d;
  logic [1:0]  piso_q, piso_d;
  logic [1:0]  accion_q, accion_d;
  logic        puertas_q, puertas_d;
  logic [1:0]  destino_q, destino_d;

  logic        pet_vld;
  logic [1:0]  pet_piso;
  logic [1:0]  piso_sig;

  always_comb begin
    pet_vld  = 1'b1;
    pet_piso = 2'd0;
    case (memoria)
      4'd1, 4'd5:        pet_piso = 2'd0;
      4'd2, 4'd6, 4'd7:  pet_piso = 2'd1;
      4'd3, 4'd8, 4'd9:  pet_piso = 2'd2;
      4'd4, 4'd10:       pet_piso = 2'd3;
      default:           pet_vld  = 1'b0;
    endcase
  end

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    fase_d    = fase_q;
    obtener_d = 1'b0;
    piso_d    = piso_q;
    accion_d  = accion_q;
    puertas_d = puertas_q;
    destino_d = destino_q;
    piso_sig  = (estado_q == SUBIR) ? piso_q + 2'd1 : piso_q - 2'd1;

    case (estado_q)
      // fase 0 raises the strobe, fase 3 is the cycle whose closing edge samples memoria
      REPOSO: begin
        accion_d  = 2'd0;
        puertas_d = 1'b0;
        obtener_d = (fase_q == 2'd0);
        fase_d    = fase_q + 2'd1;
        if (fase_q == 2'd3 && pet_vld) begin
          if (pet_piso == piso_q) begin
            estado_d = ABRIR;
          end else begin
            destino_d = pet_piso;
            estado_d  = (pet_piso > piso_q) ? SUBIR : BAJAR;
          end
        end
      end
      SUBIR, BAJAR: begin
        accion_d  = (estado_q == SUBIR) ? 2'd1 : 2'd2;
        puertas_d = 1'b0;
        fase_d    = 2'd0;
        if ((estado_q == SUBIR && piso_q == 2'd3) || (estado_q == BAJAR && piso_q == 2'd0)) begin
          cnt_d    = 16'd0;
          estado_d = ABRIR;
        end else if (cnt_q == PISO_FIN) begin
          cnt_d    = 16'd0;
          piso_d   = piso_sig;
          estado_d = (piso_sig == destino_q) ? ABRIR : LLEGADA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LLEGADA: begin
        obtener_d = (fase_q == 2'd0);
        fase_d    = fase_q + 2'd1;
        if (fase_q == 2'd3) begin
          if (pet_vld && pet_piso == piso_q) estado_d = ABRIR;
          else                               estado_d = (accion_q == 2'd2) ? BAJAR : SUBIR;
        end
      end
      ABRIR: begin
        accion_d  = 2'd0;
        puertas_d = 1'b1;
        obtener_d = (fase_q == 2'd1);
        fase_d    = fase_q + 2'd1;
        if (fase_q == 2'd2) begin
          fase_d   = 2'd0;
          cnt_d    = 16'd0;
          estado_d = ABIERTA;
        end
      end
      ABIERTA: begin
        accion_d  = 2'd0;
        puertas_d = 1'b1;
        // holding abrir pauses the door timer, extending the open time cycle for cycle
        if (!abrir) begin
          if (cnt_q == PUERTA_FIN) begin
            cnt_d     = 16'd0;
            fase_d    = 2'd0;
            puertas_d = 1'b0;
            estado_d  = REPOSO;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= 16'd0;
      fase_q    <= 2'd0;
      obtener_q <= 1'b0;
      piso_q    <= 2'd0;
      accion_q  <= 2'd0;
      puertas_q <= 1'b0;
      destino_q <= 2'd0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      fase_q    <= fase_d;
      obtener_q <= obtener_d;
      piso_q    <= piso_d;
      accion_q  <= accion_d;
      puertas_q <= puertas_d;
      destino_q <= destino_d;
    end
  end

  assign obtener   = obtener_q;
  assign piso_m    = piso_q;
  assign accion_m  = accion_q;
  assign puertas_m = puertas_q;
  assign destino   = destino_q;

endmodule

// File: tb/tb_control_ascensor.sv
// Bench for control_ascensor: expected output-change events (value + cycle gap) queued per trip, matched by a monitor.
module tb_control_ascensor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] memoria = 4'd0;
  logic       abrir = 1'b0;
  logic       obtener;
  logic [1:0] piso_m, accion_m, destino;
  logic       puertas_m;

  always #5 clk = ~clk;

  control_ascensor #(.CICLOS_PISO(100), .CICLOS_PUERTA(50)) dut (
    .clk(clk), .reset(reset), .memoria(memoria), .abrir(abrir),
    .obtener(obtener), .piso_m(piso_m), .accion_m(accion_m),
    .puertas_m(puertas_m), .destino(destino)
  );

  typedef struct {
    logic [6:0] pk;
    int         gap;
  } ev_t;

  ev_t  evq[$];
  ev_t  e_cur;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_chg = 0;
  int   last_obt = -1;
  int   obt_cnt = 0;
  bit   per_chk = 1'b0;
  logic prev_obt = 1'b0;
  logic [6:0] prev_pk = 7'd0;
  logic [6:0] cur_pk;

  assign cur_pk = {piso_m, accion_m, puertas_m, destino};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [1:0] p, input logic [1:0] a, input logic d,
                         input logic [1:0] dst, input int gap);
    ev_t e;
    e.pk  = {p, a, d, dst};
    e.gap = gap;
    evq.push_back(e);
  endtask

  task automatic wait_door(input logic v);
    int n = 0;
    while (puertas_m !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_door", puertas_m, v);
  endtask

  task automatic wait_piso(input logic [1:0] v);
    int n = 0;
    while (piso_m !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_piso", piso_m, v);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (evq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", evq.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("door_move", {30'd0, puertas_m & (accion_m != 2'd0), accion_m == 2'd3}, 0);
    if (cur_pk !== prev_pk) begin
      if (evq.size() == 0) begin
        chk("unexp_change", cur_pk, prev_pk);
      end else begin
        e_cur = evq.pop_front();
        chk("evt_val", cur_pk, e_cur.pk);
        if (e_cur.gap != 0) chk("evt_gap", cyc - last_chg, e_cur.gap);
      end
      last_chg = cyc;
      prev_pk  = cur_pk;
    end
    if (obtener) chk("obt_width", prev_obt, 0);
    if (obtener && !prev_obt) begin
      if (per_chk && last_obt >= 0) chk("obt_period", cyc - last_obt, 4);
      last_obt = cyc;
      obt_cnt++;
    end
    prev_obt = obtener;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d events pending", evq.size());
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_obtener", obtener, 0);
    chk("rst_piso", piso_m, 0);
    chk("rst_accion", accion_m, 0);
    chk("rst_puertas", puertas_m, 0);
    chk("rst_destino", destino, 0);
    reset   = 1'b0;
    per_chk = 1'b1;
    n0      = obt_cnt;

    // empty memory: idle for 200 cycles, strobe every 4
    repeat (200) @(negedge clk);
    per_chk = 1'b0;
    chk("obt_cnt_idle", obt_cnt - n0, 50);

    // up trip 0 -> 2, no query at destination
    push_ev(2'd0, 2'd0, 1'b0, 2'd2, 0);
    push_ev(2'd0, 2'd1, 1'b0, 2'd2, 1);
    push_ev(2'd1, 2'd1, 1'b0, 2'd2, 99);
    push_ev(2'd2, 2'd1, 1'b0, 2'd2, 104);
    push_ev(2'd2, 2'd0, 1'b1, 2'd2, 1);
    push_ev(2'd2, 2'd0, 1'b0, 2'd2, 52);
    memoria = 4'd3;
    wait_door(1'b1);
    memoria = 4'd0;
    drain(400);

    // same-floor request with 30-cycle door hold
    push_ev(2'd2, 2'd0, 1'b1, 2'd2, 0);
    push_ev(2'd2, 2'd0, 1'b0, 2'd2, 82);
    memoria = 4'd8;
    wait_door(1'b1);
    memoria = 4'd0;
    repeat (10) @(negedge clk);
    abrir = 1'b1;
    repeat (30) @(negedge clk);
    abrir = 1'b0;
    drain(300);

    // invalid code and abrir outside ABIERTA: no effect
    n0 = obt_cnt;
    memoria = 4'd12;
    abrir   = 1'b1;
    repeat (40) @(negedge clk);
    abrir   = 1'b0;
    memoria = 4'd0;
    chk("obt_cnt_inval", obt_cnt - n0, 10);

    // 2 -> 3
    push_ev(2'd2, 2'd0, 1'b0, 2'd3, 0);
    push_ev(2'd2, 2'd1, 1'b0, 2'd3, 1);
    push_ev(2'd3, 2'd1, 1'b0, 2'd3, 99);
    push_ev(2'd3, 2'd0, 1'b1, 2'd3, 1);
    push_ev(2'd3, 2'd0, 1'b0, 2'd3, 52);
    memoria = 4'd4;
    wait_door(1'b1);
    memoria = 4'd0;
    drain(400);

    // down toward 0, reset mid-move
    push_ev(2'd3, 2'd0, 1'b0, 2'd0, 0);
    push_ev(2'd3, 2'd2, 1'b0, 2'd0, 1);
    push_ev(2'd2, 2'd2, 1'b0, 2'd0, 99);
    push_ev(2'd0, 2'd0, 1'b0, 2'd0, 0);
    memoria = 4'd5;
    wait_piso(2'd2);
    repeat (30) @(negedge clk);
    chk("mid_accion", accion_m, 2);
    reset   = 1'b1;
    memoria = 4'd0;
    @(negedge clk);
    chk("mrst_piso", piso_m, 0);
    chk("mrst_accion", accion_m, 0);
    chk("mrst_destino", destino, 0);
    @(negedge clk);
    reset = 1'b0;
    drain(50);

    // intermediate stop at floor 1 on the way to 3
    push_ev(2'd0, 2'd0, 1'b0, 2'd3, 0);
    push_ev(2'd0, 2'd1, 1'b0, 2'd3, 1);
    push_ev(2'd1, 2'd1, 1'b0, 2'd3, 99);
    push_ev(2'd1, 2'd0, 1'b1, 2'd3, 5);
    push_ev(2'd1, 2'd0, 1'b0, 2'd3, 52);
    memoria = 4'd4;
    wait_piso(2'd1);
    memoria = 4'd7;
    wait_door(1'b1);
    memoria = 4'd0;
    drain(400);
    chk("stop_destino", destino, 3);
    chk("stop_piso", piso_m, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
